// File: rtl/patdet_pkg.sv
// patdet_pkg: LFSR tap table and match-mode encodings shared by prbs_pattern_detector.
package patdet_pkg;
    typedef enum logic {
        MODE_OVL  = 1'b0,
        MODE_NOVL = 1'b1
    } mode_e;
    // Returns zero for unsupported widths so instantiating modules can reject them.
    function automatic logic [15:0] tap_mask(input int w);
        return w == 3  ? 16'h0006 :
               w == 4  ? 16'h000C :
               w == 7  ? 16'h0060 :
               w == 15 ? 16'h6000 :
               w == 16 ? 16'hD008 : 16'h0000;
    endfunction
endpackage

// File: rtl/patdet_lfsr.sv
// patdet_lfsr: Fibonacci LFSR with seed load; a zero seed or zero state is replaced by all-ones.
module patdet_lfsr
    import patdet_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] seed,
    output logic         fb
);
    localparam logic [15:0] MASK16 = tap_mask(W);
    localparam logic [W-1:0] MASK = MASK16[W-1:0];
    if (MASK16 == 16'h0000) begin : g_bad_width
        $error("patdet_lfsr: LFSR width must be 3, 4, 7, 15 or 16");
    end
    logic [W-1:0] lfsr_q, lfsr_d, nxt;
    assign fb = ^(lfsr_q & MASK);
    always_comb begin
        nxt = load ? (seed == '0 ? '1 : seed) : step ? {lfsr_q[W-2:0], fb} : lfsr_q;
        lfsr_d = nxt == '0 ? '1 : nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= '1;
        else lfsr_q <= lfsr_d;
    end
endmodule

// File: rtl/prbs_pattern_detector.sv
// prbs_pattern_detector: prescaled PRBS generator with a sliding-window pattern matcher.
// Define PATDET_CNT_EN to add the saturating match_cnt output.
module prbs_pattern_detector
    import patdet_pkg::*;
#(
    parameter int LFSR_W = 7,
    parameter int PAT_W  = 4,
    parameter int DIV    = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              mode,
    output logic              prbs_bit,
    output logic [PAT_W-1:0]  window,
    output logic              primed,
    output logic              match
`ifdef PATDET_CNT_EN
    ,
    output logic [CNT_W-1:0]  match_cnt
`endif
);
    localparam int PSW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    localparam logic [PSW-1:0] PS_END = PSW'(DIV - 1);
    if (PAT_W < 2 || PAT_W > 32 || DIV < 1 || CNT_W < 1) begin : g_bad_param
        $error("prbs_pattern_detector: PAT_W must be 2..32, DIV and CNT_W at least 1");
    end
    logic [PSW-1:0]   presc_q, presc_d;
    logic [PAT_W-1:0] window_q, window_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             prbs_bit_q, prbs_bit_d, match_q, match_d, step, fb;
    // A seed load swallows the step that would otherwise land on this cycle.
    assign step = presc_q == PS_END && !seed_load;
    patdet_lfsr #(.W(LFSR_W)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .load (seed_load),
        .seed (seed),
        .fb   (fb)
    );
    always_comb begin
        presc_d = seed_load || presc_q == PS_END ? '0 : presc_q + 1'b1;
        window_d = seed_load ? '0 : step ? {window_q[PAT_W-2:0], fb} : window_q;
        prbs_bit_d = step ? fb : prbs_bit_q;
        fill_d = seed_load ? '0 : step && fill_q != FULL ? fill_q + 1'b1 : fill_q;
        match_d = step && window_d == pattern && fill_d == FULL;
        if (match_d && mode == MODE_NOVL) fill_d = '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            window_q   <= '0;
            fill_q     <= '0;
            prbs_bit_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            window_q   <= window_d;
            fill_q     <= fill_d;
            prbs_bit_q <= prbs_bit_d;
            match_q    <= match_d;
        end
    end
    assign prbs_bit = prbs_bit_q;
    assign window   = window_q;
    assign primed   = fill_q == FULL;
    assign match    = match_q;
`ifdef PATDET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign cnt_d = match_d && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign match_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_prbs_pattern_detector.sv
// tb_prbs_pattern_detector: two detectors (3-bit LFSR; PAT_W=4/DIV=1 and PAT_W=2/DIV=4)
// checked every cycle against a stream-level model plus hand-computed sequences.
module tb_prbs_pattern_detector;
    logic clk = 0, rst = 0, seed_load = 0, mode_a = 0, mode_b = 0;
    logic [2:0] seed = 3'b001;
    logic [3:0] pat_a = 4'b0111;
    logic [1:0] pat_b = 2'b11;
    logic prbs_a, prbs_b, primed_a, primed_b, match_a, match_b;
    logic [3:0] win_a;
    logic [1:0] win_b;
`ifdef PATDET_CNT_EN
    logic [1:0]  cnt_a;
    logic [15:0] cnt_b;
`endif
    int errors = 0, checks = 0;
    int m_lfsr[2], m_win[2], m_since[2], m_bit[2], m_match[2], m_tick[2], m_cnt[2];
    int a_bit[1:56], a_m[1:56], a_c[1:56], b_m[1:14], b_w[1:56];
    logic [0:6] seq_seed1 = 7'b0111001;
    logic [0:6] seq_ones = 7'b0010111;

    always #5 clk = ~clk;

    prbs_pattern_detector #(.LFSR_W(3), .PAT_W(4), .DIV(1), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .pattern(pat_a), .mode(mode_a),
        .prbs_bit(prbs_a), .window(win_a), .primed(primed_a), .match(match_a)
`ifdef PATDET_CNT_EN
        , .match_cnt(cnt_a)
`endif
    );
    prbs_pattern_detector #(.LFSR_W(3), .PAT_W(2), .DIV(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .pattern(pat_b), .mode(mode_b),
        .prbs_bit(prbs_b), .window(win_b), .primed(primed_b), .match(match_b)
`ifdef PATDET_CNT_EN
        , .match_cnt(cnt_b)
`endif
    );

    function automatic int pw(int d);
        return d == 0 ? 4 : 2;
    endfunction
    function automatic int dv(int d);
        return d == 0 ? 1 : 4;
    endfunction
    function automatic int cmax(int d);
        return d == 0 ? 3 : 65535;
    endfunction
    function automatic int pat(int d);
        return d == 0 ? int'(pat_a) : int'(pat_b);
    endfunction
    function automatic int md(int d);
        return d == 0 ? int'(mode_a) : int'(mode_b);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: the taps 110 make each new bit the parity of the two oldest state bits;
    // m_since counts bits since the window was last emptied.
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_lfsr[d] = 7; m_win[d] = 0; m_since[d] = 0; m_bit[d] = 0;
                m_match[d] = 0; m_tick[d] = 0; m_cnt[d] = 0;
            end else begin
                m_match[d] = 0;
                if (seed_load) begin
                    m_lfsr[d] = seed == 0 ? 7 : int'(seed);
                    m_win[d] = 0; m_since[d] = 0; m_tick[d] = 0;
                end else begin
                    m_tick[d] += 1;
                    if (m_tick[d] == dv(d)) begin
                        m_tick[d] = 0;
                        m_bit[d] = $countones(m_lfsr[d] & 6) % 2;
                        m_lfsr[d] = (2 * m_lfsr[d] + m_bit[d]) % 8;
                        m_win[d] = (2 * m_win[d] + m_bit[d]) % (1 << pw(d));
                        m_since[d] += 1;
                        if (m_since[d] >= pw(d) && m_win[d] == pat(d)) begin
                            m_match[d] = 1;
                            if (m_cnt[d] < cmax(d)) m_cnt[d] += 1;
                            if (md(d) != 0) m_since[d] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_prbs", int'(prbs_a), m_bit[0]);
            chk("a_window", int'(win_a), m_win[0]);
            chk("a_primed", int'(primed_a), int'(m_since[0] >= 4));
            chk("a_match", int'(match_a), m_match[0]);
            chk("b_prbs", int'(prbs_b), m_bit[1]);
            chk("b_window", int'(win_b), m_win[1]);
            chk("b_primed", int'(primed_b), int'(m_since[1] >= 2));
            chk("b_match", int'(match_b), m_match[1]);
`ifdef PATDET_CNT_EN
            chk("a_cnt", int'(cnt_a), m_cnt[0]);
            chk("b_cnt", int'(cnt_b), m_cnt[1]);
`endif
        end
    end

    task automatic load(input logic [2:0] s);
        seed = s;
        seed_load = 1;
        @(negedge clk);
        seed_load = 0;
    endtask

    task automatic run(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            a_bit[c] = int'(prbs_a);
            a_m[c] = int'(match_a);
            b_w[c] = int'(win_b);
`ifdef PATDET_CNT_EN
            a_c[c] = int'(cnt_a);
`else
            a_c[c] = 0;
`endif
            if (c % 4 == 0 && c / 4 <= 14) b_m[c / 4] = int'(match_b);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rst_prbs_a"}, int'(prbs_a), 0);
        chk({tag, "_rst_win_a"}, int'(win_a), 0);
        chk({tag, "_rst_primed_a"}, int'(primed_a), 0);
        chk({tag, "_rst_match_a"}, int'(match_a), 0);
        chk({tag, "_rst_prbs_b"}, int'(prbs_b), 0);
        chk({tag, "_rst_win_b"}, int'(win_b), 0);
        chk({tag, "_rst_primed_b"}, int'(primed_b), 0);
        chk({tag, "_rst_match_b"}, int'(match_b), 0);
`ifdef PATDET_CNT_EN
        chk({tag, "_rst_cnt_a"}, int'(cnt_a), 0);
        chk({tag, "_rst_cnt_b"}, int'(cnt_b), 0);
`endif
    endtask

    initial begin
        #1 rst = 1;
        #2 reset_checks("por");
        @(negedge clk) rst = 0;
        // Seed 001, overlapping mode on both detectors.
        load(3'b001);
        run(56);
        for (int c = 1; c <= 14; c++) begin
            chk("seed1_bit", a_bit[c], int'(seq_seed1[(c - 1) % 7]));
            chk("seed1_match_0111", a_m[c], int'(c == 4 || c == 11));
            chk("ovl_match_11", b_m[c], int'(c == 3 || c == 4 || c == 10 || c == 11));
        end
        chk("div4_hold_step2", b_w[11], 1);
        chk("div4_step3", b_w[12], 3);
        chk("div4_hold_step3", b_w[15], 3);
        chk("a_cnt_seq1", a_c[4], `ifdef PATDET_CNT_EN 1 `else 0 `endif);
        chk("a_cnt_seq2", a_c[11], `ifdef PATDET_CNT_EN 2 `else 0 `endif);
        chk("a_cnt_seq3", a_c[18], `ifdef PATDET_CNT_EN 3 `else 0 `endif);
        chk("a_cnt_seq4", a_c[25], `ifdef PATDET_CNT_EN 3 `else 0 `endif);
        chk("a_cnt_seq5", a_c[32], `ifdef PATDET_CNT_EN 3 `else 0 `endif);
        // Non-overlapping mode on the 2-bit detector; reload mid-count.
        mode_b = 1;
        load(3'b001);
        chk("load_win_a", int'(win_a), 0);
        chk("load_primed_a", int'(primed_a), 0);
        chk("load_match_a", int'(match_a), 0);
        chk("load_win_b", int'(win_b), 0);
`ifdef PATDET_CNT_EN
        chk("load_keeps_cnt", int'(cnt_a), 3);
`endif
        run(56);
        for (int k = 1; k <= 14; k++) chk("novl_match_11", b_m[k], int'(k == 3 || k == 10));
        // Zero seed behaves as all-ones.
        load(3'b000);
        run(3);
        for (int c = 1; c <= 3; c++) chk("seed0_bit", a_bit[c], int'(seq_ones[c - 1]));
        chk("seed0_window", int'(win_a), 1);
        chk("seed0_b_idle", int'(win_b), 0);
        // Reset between step 2 and step 3 of the 0111 case.
        mode_b = 0;
        load(3'b001);
        run(2);
        chk("pre_rst_bit", a_bit[2], 1);
        chk("pre_rst_win", int'(win_a), 1);
        #2 rst = 1;
        #1 reset_checks("mid");
        @(negedge clk) rst = 0;
        run(7);
        for (int c = 1; c <= 7; c++) begin
            chk("post_rst_bit", a_bit[c], int'(seq_ones[c - 1]));
            chk("post_rst_match", a_m[c], int'(c == 7));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
